fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/datapath_pkg.sv | 29 ++
 rtl/fetch_btb.sv | 58 +++++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath types for the fetch stage: instruction-queue entry, BTB entry,
// default sizing and the 2-bit branch counter step.
package datapath_pkg;

   localparam int DEF_IQ_DEPTH    = 4;
   localparam int DEF_BTB_ENTRIES = 16;

   // Fetch field handed to dispatch, plus the PC of the instruction.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] br_pc;
      logic        br_pred;
   } fetch_entry_t;

   // Tag is the full PC with the index bits cleared, so it is independent of BTB size.
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
      logic [31:0] target;
      logic [1:0]  cnt;
   } btb_entry_t;

   function automatic logic [1:0] cnt_step(input logic [1:0] c, input logic taken);
      if (taken) return (c == 2'b11) ? c : c + 2'b01;
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// registered update from the resolved-branch port.
module fetch_btb
   import datapath_pkg::*;
#(
   parameter int BTB_ENTRIES = DEF_BTB_ENTRIES
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] lookup_pc,
   output logic        pred,
   output logic [31:0] target,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken
);

   localparam int          IDX_W    = $clog2(BTB_ENTRIES);
   localparam logic [31:0] IDX_MASK = 32'(((1 << IDX_W) - 1) << 2);

   btb_entry_t             tbl [BTB_ENTRIES];
   btb_entry_t             lk_ent;
   btb_entry_t             up_ent;
   logic [IDX_W-1:0]       lk_idx;
   logic [IDX_W-1:0]       up_idx;
   logic                   lk_hit;
   logic                   up_hit;

   assign lk_idx = lookup_pc[2 +: IDX_W];
   assign up_idx = upd_pc[2 +: IDX_W];
   assign lk_ent = tbl[lk_idx];
   assign up_ent = tbl[up_idx];

   assign lk_hit = lk_ent.valid && (lk_ent.tag == (lookup_pc & ~IDX_MASK));
   assign up_hit = up_ent.valid && (up_ent.tag == (upd_pc & ~IDX_MASK));

   // Lookup reads the table before this edge's update lands.
   assign pred   = lk_hit & lk_ent.cnt[1];
   assign target = lk_ent.target;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: 2'b01};
         end
      end else if (upd_en) begin
         if (up_hit) begin
            tbl[up_idx].cnt <= cnt_step(up_ent.cnt, upd_taken);
            if (upd_taken) tbl[up_idx].target <= upd_target;
         end else if (upd_taken) begin
            tbl[up_idx] <= '{valid: 1'b1, tag: upd_pc & ~IDX_MASK,
                             target: upd_target, cnt: 2'b10};
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BTB-driven next-PC prediction and a small
// instruction queue whose head is presented to dispatch with zero latency.
module fetch_stage
   import datapath_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          IQ_DEPTH    = DEF_IQ_DEPTH,
   parameter int          BTB_ENTRIES = DEF_BTB_ENTRIES
) (
   input  logic        CLK,
   input  logic        nRST,
   output logic        imem_ren,
   output logic [31:0] imem_addr,
   input  logic        ihit,
   input  logic [31:0] imem_load,
   input  logic        freeze,
   input  logic        branch_miss,
   input  logic [31:0] correct_pc,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   output logic        valid,
   output logic [31:0] imemload,
   output logic [31:0] pc,
   output logic [31:0] br_pc,
   output logic        br_pred
);

   localparam int PTR_W = $clog2(IQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [31:0]    fetch_pc;
   logic [31:0]    next_pc;
   logic [31:0]    btb_target;
   logic           pred;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic           full;
   logic           push;
   logic           pop;
   fetch_entry_t   iq [IQ_DEPTH];
   fetch_entry_t   head_ent;

   fetch_btb #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
      .CLK        (CLK),
      .nRST       (nRST),
      .lookup_pc  (fetch_pc),
      .pred       (pred),
      .target     (btb_target),
      .upd_en     (upd_en),
      .upd_pc     (upd_pc),
      .upd_target (upd_target),
      .upd_taken  (upd_taken)
   );

   // Request uses the registered count, so a full queue stalls even when popping.
   assign full      = (count == CNT_W'(IQ_DEPTH));
   assign imem_ren  = nRST & ~full & ~branch_miss;
   assign imem_addr = fetch_pc;
   assign next_pc   = pred ? btb_target : fetch_pc + 32'd4;

   assign valid = nRST & (count != '0);
   assign push  = imem_ren & ihit;
   assign pop   = valid & ~freeze;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         fetch_pc <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else if (branch_miss) begin
         fetch_pc <= correct_pc;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            fetch_pc <= next_pc;
            tail     <= tail + 1'b1;
         end
         if (pop) head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the count gates everything read from it.
   always_ff @(posedge CLK) begin
      if (push) begin
         iq[tail] <= '{instr: imem_load, pc: fetch_pc, br_pc: next_pc, br_pred: pred};
      end
   end

   assign head_ent = iq[head];
   assign imemload = valid ? head_ent.instr   : '0;
   assign pc       = valid ? head_ent.pc      : '0;
   assign br_pc    = valid ? head_ent.br_pc   : '0;
   assign br_pred  = valid ? head_ent.br_pred : 1'b0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random
// traffic, all checked each cycle against a queue/array behavioural model.
module tb_fetch_stage;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        imem_ren;
   logic [31:0] imem_addr;
   logic        ihit;
   logic [31:0] imem_load;
   logic        freeze;
   logic        branch_miss;
   logic [31:0] correct_pc;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        valid;
   logic [31:0] imemload;
   logic [31:0] pc;
   logic [31:0] br_pc;
   logic        br_pred;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   fetch_stage #(.RESET_PC(32'h0), .IQ_DEPTH(4), .BTB_ENTRIES(16)) dut (
      .CLK(CLK), .nRST(nRST), .imem_ren(imem_ren), .imem_addr(imem_addr),
      .ihit(ihit), .imem_load(imem_load), .freeze(freeze),
      .branch_miss(branch_miss), .correct_pc(correct_pc),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
      .valid(valid), .imemload(imemload), .pc(pc), .br_pc(br_pc), .br_pred(br_pred)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
   endfunction

   assign imem_load = mem_word(imem_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] br_pc;
      logic        pred;
   } ment_t;

   ment_t       mq[$];
   logic [31:0] m_pc;
   bit          bv   [16];
   logic [31:0] btag [16];
   logic [31:0] btgt [16];
   int          bcnt [16];

   function automatic int bidx(input logic [31:0] a);
      return int'((a >> 2) % 16);
   endfunction

   function automatic bit m_predict(input logic [31:0] a);
      int i;
      i = bidx(a);
      return bv[i] && (btag[i] == (a >> 6)) && (bcnt[i] >= 2);
   endfunction

   always @(posedge CLK) begin : model
      logic [31:0] nxt;
      bit          p;
      bit          ren;
      bit          uhit;
      int          ui;
      ment_t       e;
      if (!nRST) begin
         mq.delete();
         m_pc = 32'h0;
         for (int i = 0; i < 16; i++) begin
            bv[i]   = 1'b0;
            bcnt[i] = 1;
            btag[i] = '0;
            btgt[i] = '0;
         end
      end else begin
         p    = m_predict(m_pc);
         nxt  = p ? btgt[bidx(m_pc)] : m_pc + 32'd4;
         ren  = (mq.size() < 4) && !branch_miss;
         ui   = bidx(upd_pc);
         uhit = bv[ui] && (btag[ui] == (upd_pc >> 6));
         if (branch_miss) begin
            mq.delete();
            m_pc = correct_pc;
         end else begin
            if (mq.size() > 0 && !freeze) void'(mq.pop_front());
            if (ren && ihit) begin
               e.instr = mem_word(m_pc);
               e.pc    = m_pc;
               e.br_pc = nxt;
               e.pred  = p;
               mq.push_back(e);
               m_pc = nxt;
            end
         end
         if (upd_en) begin
            if (uhit) begin
               if (upd_taken) begin
                  if (bcnt[ui] < 3) bcnt[ui] = bcnt[ui] + 1;
                  btgt[ui] = upd_target;
               end else if (bcnt[ui] > 0) begin
                  bcnt[ui] = bcnt[ui] - 1;
               end
            end else if (upd_taken) begin
               bv[ui]   = 1'b1;
               btag[ui] = upd_pc >> 6;
               btgt[ui] = upd_target;
               bcnt[ui] = 2;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CLK) begin : compare
      bit    mv;
      ment_t h;
      if (chk_en) begin
         mv = nRST && (mq.size() > 0);
         if (mv) h = mq[0];
         else begin
            h.instr = '0; h.pc = '0; h.br_pc = '0; h.pred = 1'b0;
         end
         chk("imem_ren",  32'(imem_ren), 32'(nRST && (mq.size() < 4) && !branch_miss));
         chk("imem_addr", imem_addr, m_pc);
         chk("valid",     32'(valid), 32'(mv));
         chk("imemload",  imemload, h.instr);
         chk("pc",        pc, h.pc);
         chk("br_pc",     br_pc, h.br_pc);
         chk("br_pred",   32'(br_pred), 32'(h.pred));
      end
   end

   // ---------------- stimulus ----------------
   task automatic settle();
      @(negedge CLK);
   endtask

   task automatic adv();
      @(posedge CLK);
      #1;
   endtask

   task automatic redirect(input logic [31:0] target);
      branch_miss = 1'b1;
      correct_pc  = target;
      adv();
      branch_miss = 1'b0;
   endtask

   initial begin
      nRST = 1'b0; ihit = 1'b0; freeze = 1'b0; branch_miss = 1'b0; correct_pc = '0;
      upd_en = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
      adv();
      chk_en = 1'b1;
      settle();
      chk("rst_ren",   32'(imem_ren), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_addr",  imem_addr, 32'h0);
      adv();

      // sequential fetch
      nRST = 1'b1; ihit = 1'b1;
      settle();
      chk("seq_addr0", imem_addr, 32'h0);
      chk("seq_ren0",  32'(imem_ren), 32'h1);
      adv();
      settle();
      chk("seq_valid1", 32'(valid), 32'h1);
      chk("seq_pc1",    pc, 32'h0);
      chk("seq_brpc1",  br_pc, 32'h4);
      chk("seq_addr1",  imem_addr, 32'h4);
      adv();
      settle();
      chk("seq_addr2", imem_addr, 32'h8);
      adv();
      repeat (4) adv();

      // freeze fills the queue, release drains it in order
      redirect(32'h0);
      freeze = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            settle();
            chk("frz_ren",  32'(imem_ren), 32'h0);
            chk("frz_head", pc, 32'h0);
            chk("frz_addr", imem_addr, 32'h10);
         end
         adv();
      end
      freeze = 1'b0;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk("drain_pc", pc, 32'(k * 4));
         adv();
      end

      // BTB training to taken
      ihit = 1'b0;
      upd_en = 1'b1; upd_pc = 32'h10; upd_target = 32'h40; upd_taken = 1'b1;
      adv(); adv();
      upd_en = 1'b0;
      redirect(32'h10);
      ihit = 1'b1;
      settle();
      chk("btb_addr", imem_addr, 32'h10);
      adv();
      settle();
      chk("btb_pred",  32'(br_pred), 32'h1);
      chk("btb_brpc",  br_pc, 32'h40);
      chk("btb_next",  imem_addr, 32'h40);
      adv();

      // counter walks down to strongly not-taken
      ihit = 1'b0;
      upd_en = 1'b1; upd_taken = 1'b0;
      repeat (3) adv();
      upd_en = 1'b0;
      redirect(32'h10);
      ihit = 1'b1;
      adv();
      settle();
      chk("nt_pred", 32'(br_pred), 32'h0);
      chk("nt_brpc", br_pc, 32'h14);
      adv();

      // PC wrap
      redirect(32'hFFFF_FFFC);
      settle();
      chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      adv();
      settle();
      chk("wrap_addr1", imem_addr, 32'h0);
      chk("wrap_brpc",  br_pc, 32'h0);
      adv();

      // flush with 3 queued and a same-cycle hit
      freeze = 1'b1;
      redirect(32'h100);
      repeat (3) adv();
      branch_miss = 1'b1; correct_pc = 32'h80; freeze = 1'b0;
      settle();
      chk("miss_ren", 32'(imem_ren), 32'h0);
      adv();
      branch_miss = 1'b0;
      settle();
      chk("miss_valid", 32'(valid), 32'h0);
      chk("miss_addr",  imem_addr, 32'h80);
      adv();

      // reset mid-operation
      adv();
      nRST = 1'b0;
      settle();
      chk("mrst_ren", 32'(imem_ren), 32'h0);
      adv();
      nRST = 1'b1;
      settle();
      chk("mrst_ren1",  32'(imem_ren), 32'h1);
      chk("mrst_addr",  imem_addr, 32'h0);
      chk("mrst_valid", 32'(valid), 32'h0);
      adv();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         nRST        = ($urandom_range(0, 99) != 0);
         ihit        = ($urandom_range(0, 3) != 0);
         freeze      = ($urandom_range(0, 3) == 0);
         branch_miss = ($urandom_range(0, 15) == 0);
         correct_pc  = 32'($urandom_range(0, 31)) << 2;
         upd_en      = ($urandom_range(0, 2) == 0);
         upd_pc      = 32'($urandom_range(0, 31)) << 2;
         upd_target  = 32'($urandom_range(0, 63)) << 2;
         upd_taken   = ($urandom_range(0, 2) != 0);
         adv();
      end

      nRST = 1'b1; branch_miss = 1'b0; upd_en = 1'b0;
      adv();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
